// File: rtl/vec_to_loc_extractor.sv
// Dense-to-sparse converter: scans a dense vector held in a WIDTH-wide memory and
// emits the bit index of every set bit, in ascending order, into a location memory.
module vec_to_loc_extractor #(
  parameter parameter_set = "hqc128",
  parameter int unsigned N      = (parameter_set == "hqc256") ? 57637 :
                                  (parameter_set == "hqc192") ? 35851 : 17669,
  parameter int unsigned M      = (parameter_set == "hqc128") ? 15 : 16,
  parameter int unsigned WEIGHT = (parameter_set == "hqc256") ? 131 :
                                  (parameter_set == "hqc192") ? 100 : 66,
  parameter int unsigned WIDTH  = 32,
  localparam int unsigned N_MEM      = ((N + WIDTH - 1) / WIDTH) * WIDTH,
  localparam int unsigned DEPTH      = N_MEM / WIDTH,
  localparam int unsigned LOG_DEPTH  = $clog2(DEPTH),
  localparam int unsigned LOG_WEIGHT = $clog2(WEIGHT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  vec_rd_en,
  output logic [LOG_DEPTH-1:0]  vec_rd_addr,
  input  logic [WIDTH-1:0]      vec_in,
  output logic                  loc_wr_en,
  output logic [LOG_WEIGHT-1:0] loc_wr_addr,
  output logic [M-1:0]          loc_out,
  output logic [LOG_WEIGHT-1:0] weight_count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LOG_WIDTH = $clog2(WIDTH);
  localparam int unsigned REM       = N % WIDTH;
  // Padding bits above N in the last word must never produce a location.
  localparam logic [WIDTH-1:0] LAST_MASK =
    (REM == 0) ? {WIDTH{1'b1}} : WIDTH'((65'(1) << REM) - 65'(1));
  localparam logic [LOG_DEPTH-1:0]  LAST_IDX = LOG_DEPTH'(DEPTH - 1);
  localparam logic [LOG_WEIGHT-1:0] MAX_CNT  = LOG_WEIGHT'(WEIGHT);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LOAD, S_SCAN, S_FIN} state_t;

  state_t                 state;
  logic [LOG_DEPTH-1:0]   word_idx;
  logic [WIDTH-1:0]       word_reg;
  logic                   last_word;
  logic [WIDTH-1:0]       masked_word;
  logic [WIDTH-1:0]       cleared_word;
  logic [LOG_WIDTH-1:0]   low_bit;

  function automatic logic [LOG_WIDTH-1:0] lowest_set(input logic [WIDTH-1:0] w);
    lowest_set = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w[i]) lowest_set = LOG_WIDTH'(i);
    end
  endfunction

  assign vec_rd_en    = (state == S_READ);
  assign vec_rd_addr  = word_idx;
  assign last_word    = (word_idx == LAST_IDX);
  assign masked_word  = vec_in & (last_word ? LAST_MASK : {WIDTH{1'b1}});
  assign low_bit      = lowest_set(word_reg);
  assign cleared_word = word_reg & (word_reg - WIDTH'(1));

  // Scan controller; an emptied word moves on to the next read or finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      word_idx     <= '0;
      word_reg     <= '0;
      loc_wr_en    <= 1'b0;
      loc_wr_addr  <= '0;
      loc_out      <= '0;
      weight_count <= '0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      loc_wr_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_READ;
            busy         <= 1'b1;
            word_idx     <= '0;
            weight_count <= '0;
            overflow     <= 1'b0;
          end
        end
        S_READ: state <= S_LOAD;
        S_LOAD: begin
          word_reg <= masked_word;
          if (masked_word != '0) begin
            state <= S_SCAN;
          end else if (last_word) begin
            state <= S_FIN;
          end else begin
            word_idx <= word_idx + LOG_DEPTH'(1);
            state    <= S_READ;
          end
        end
        S_SCAN: begin
          if (weight_count == MAX_CNT) begin
            overflow <= 1'b1;
            state    <= S_FIN;
          end else begin
            loc_wr_en    <= 1'b1;
            loc_wr_addr  <= weight_count;
            loc_out      <= M'({word_idx, low_bit});
            weight_count <= weight_count + LOG_WEIGHT'(1);
            word_reg     <= cleared_word;
            if (cleared_word == '0) begin
              if (last_word) begin
                state <= S_FIN;
              end else begin
                word_idx <= word_idx + LOG_DEPTH'(1);
                state    <= S_READ;
              end
            end
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
